// File: rtl/slink_stream_dechopper_flush.sv
// Serial-link RX dechopper: packs chopped beats of 0..Width LSB-contiguous elements into full words.
// Partial words leave on an explicit flush or an idle timeout. Full beats arriving into an empty block bypass it.
module slink_stream_dechopper_flush #(
  parameter type         element_t         = logic [15:0],
  parameter int unsigned Width             = 4,
  parameter int unsigned FlushCounterWidth = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         bypass_en_i,
  input  logic                         flush_i,
  input  logic [FlushCounterWidth-1:0] flush_timeout_i,
  input  logic [Width-1:0]             valid_i,
  output logic                         ready_o,
  input  element_t [Width-1:0]         data_i,
  output logic                         valid_o,
  output logic [Width-1:0]             keep_o,
  input  logic                         ready_i,
  output element_t [Width-1:0]         data_o,
  output logic [$clog2(Width):0]       fill_count_o
);

  localparam int CW = $clog2(Width) + 1;
  localparam int IW = (Width > 1) ? $clog2(Width) : 1;

  element_t [Width-1:0]         r_acc;
  logic [CW-1:0]                r_fill;
  logic [CW-1:0]                r_consumed;
  logic                         r_out_valid;
  logic [Width-1:0]             r_out_keep;
  element_t [Width-1:0]         r_out_data;
  logic [FlushCounterWidth-1:0] r_idle_cnt;
  logic                         r_flush_pend;

  logic [CW-1:0]        w_k;
  logic                 w_run;
  logic                 w_out_free;
  logic                 w_bypass;
  logic                 w_auto;
  logic                 w_flush_act;
  logic                 w_flush_exec;
  logic                 w_complete;
  logic                 w_beat;
  logic                 w_take;
  logic                 w_beat_done;
  int                   w_avail;
  int                   w_room;
  int                   w_n;
  int                   w_src;
  element_t [Width-1:0] w_merged;
  logic [Width-1:0]     w_flush_keep;

  // k = number of trailing ones; anything above the first zero is ignored
  always_comb begin
    w_k   = '0;
    w_run = 1'b1;
    for (int i = 0; i < Width; i++) begin
      if (w_run && valid_i[i]) w_k = w_k + CW'(1);
      else                     w_run = 1'b0;
    end
  end

  always_comb begin
    w_out_free   = !r_out_valid || ready_i;
    w_bypass     = bypass_en_i ||
                   (w_k == CW'(Width) && r_fill == '0 && r_consumed == '0 &&
                    !r_out_valid && !r_flush_pend);
    w_auto       = (flush_timeout_i != '0) && (r_idle_cnt == flush_timeout_i);
    w_flush_act  = r_flush_pend || w_auto;
    w_flush_exec = w_flush_act && (w_out_free || r_fill == '0);

    w_avail     = (w_k > r_consumed) ? int'(w_k) - int'(r_consumed) : 0;
    w_room      = int'(Width) - int'(r_fill);
    w_n         = (w_room < w_avail) ? w_room : w_avail;
    w_complete  = (int'(r_fill) + w_n) == int'(Width);
    w_beat      = !clear_i && !w_bypass && !w_flush_act && (w_k != '0);
    w_take      = w_beat && (w_avail > 0) && (!w_complete || w_out_free);
    w_beat_done = w_take && ((int'(r_consumed) + w_n) == int'(w_k));

    w_src = 0;
    for (int i = 0; i < Width; i++) begin
      w_merged[i]     = r_acc[i];
      w_flush_keep[i] = (i < int'(r_fill));
      if (i >= int'(r_fill) && i < int'(r_fill) + w_n) begin
        w_src = int'(r_consumed) + i - int'(r_fill);
        if (w_src < int'(Width)) w_merged[i] = data_i[IW'(w_src)];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc        <= '0;
      r_fill       <= '0;
      r_consumed   <= '0;
      r_out_valid  <= 1'b0;
      r_out_keep   <= '0;
      r_out_data   <= '0;
      r_idle_cnt   <= '0;
      r_flush_pend <= 1'b0;
    end else if (clear_i) begin
      r_acc        <= '0;
      r_fill       <= '0;
      r_consumed   <= '0;
      r_out_valid  <= 1'b0;
      r_out_keep   <= '0;
      r_out_data   <= '0;
      r_idle_cnt   <= '0;
      r_flush_pend <= 1'b0;
    end else if (w_bypass) begin
      r_idle_cnt <= '0;
    end else begin
      r_flush_pend <= (r_flush_pend && !w_flush_exec) || flush_i;

      if (w_flush_exec && r_fill != '0) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_acc;
        r_out_keep  <= w_flush_keep;
        r_acc       <= '0;
        r_fill      <= '0;
      end else if (w_take && w_complete) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_merged;
        r_out_keep  <= '1;
        r_acc       <= '0;
        r_fill      <= '0;
      end else begin
        if (ready_i) r_out_valid <= 1'b0;
        if (w_take) begin
          r_acc  <= w_merged;
          r_fill <= CW'(int'(r_fill) + w_n);
        end
      end

      if (w_take) r_consumed <= w_beat_done ? '0 : CW'(int'(r_consumed) + w_n);

      // hold the count while an auto-flush waits for the output, so the trigger is not lost
      if (w_flush_exec || w_take || r_fill == '0) r_idle_cnt <= '0;
      else if (w_auto)                             r_idle_cnt <= r_idle_cnt;
      else if (r_idle_cnt != '1)                   r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  always_comb begin
    valid_o      = !clear_i && (w_bypass ? (w_k != '0) : r_out_valid);
    ready_o      = !clear_i && (w_bypass ? ready_i : w_beat_done);
    data_o       = w_bypass ? data_i  : r_out_data;
    keep_o       = w_bypass ? valid_i : r_out_keep;
    fill_count_o = r_fill;
  end

endmodule

// File: tb/tb_slink_stream_dechopper_flush.sv
// Randomized bench for slink_stream_dechopper_flush against a queue-based element model.
// Beats are held until fully consumed; every cycle's outputs are compared at the falling edge.
module tb_slink_stream_dechopper_flush;

  localparam int W   = 4;
  localparam int FCW = 6;
  localparam int IMX = (1 << FCW) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear = 1'b0;
  logic                 byp_en = 1'b0;
  logic                 flush = 1'b0;
  logic [FCW-1:0]       tmo = '0;
  logic [W-1:0]         vin = '0;
  logic [W-1:0][15:0]   din = '0;
  logic                 rdy_in = 1'b0;
  logic                 rdy_out;
  logic                 vout;
  logic [W-1:0]         keep;
  logic [W-1:0][15:0]   dout;
  logic [$clog2(W):0]   fill_cnt;

  slink_stream_dechopper_flush #(
    .element_t(logic [15:0]), .Width(W), .FlushCounterWidth(FCW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bypass_en_i(byp_en),
    .flush_i(flush), .flush_timeout_i(tmo), .valid_i(vin), .ready_o(rdy_out),
    .data_i(din), .valid_o(vout), .keep_o(keep), .ready_i(rdy_in),
    .data_o(dout), .fill_count_o(fill_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference state: held elements as a queue, output register, idle timer, flush request
  logic [15:0]        m_acc[$];
  int                 m_cons = 0;
  bit                 m_ov = 0;
  logic [W-1:0]       m_okeep = '0;
  logic [W-1:0][15:0] m_odata = '0;
  int                 m_idle = 0;
  bit                 m_pend = 0;
  bit                 last_er = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ones_run(input logic [W-1:0] v);
    int k = 0;
    while (k < W && v[k]) k++;
    return k;
  endfunction

  task automatic model_cycle();
    int k, sz, n, avail;
    bit ofree, byp, autof, ev, er, load, took, exec;
    logic [W-1:0] ek;
    logic [W-1:0][15:0] ed;
    k     = ones_run(vin);
    sz    = m_acc.size();
    ofree = !m_ov || rdy_in;
    byp   = byp_en || (k == W && sz == 0 && m_cons == 0 && !m_ov && !m_pend);
    autof = (tmo != 0) && (m_idle == int'(tmo));
    er = 0; load = 0; took = 0; exec = 0;
    if (byp) begin ev = (k > 0); ek = vin; ed = din; end
    else     begin ev = m_ov;    ek = m_okeep; ed = m_odata; end
    if (clear) ev = 0;

    if (clear) begin
      m_acc.delete(); m_cons = 0; m_ov = 0; m_okeep = '0; m_odata = '0; m_idle = 0; m_pend = 0;
    end else if (byp) begin
      er = rdy_in;
      m_idle = 0;
    end else begin
      if (m_pend || autof) begin
        if (sz == 0) begin
          exec = 1; m_pend = 0;
        end else if (ofree) begin
          exec = 1; m_pend = 0; load = 1;
          m_odata = '0; m_okeep = '0;
          for (int i = 0; i < sz; i++) begin m_odata[i] = m_acc[i]; m_okeep[i] = 1'b1; end
          m_acc.delete();
        end
      end else if (k > 0) begin
        avail = k - m_cons;
        n = (W - sz < avail) ? W - sz : avail;
        if (sz + n < W || ofree) begin
          took = 1;
          for (int j = 0; j < n; j++) m_acc.push_back(din[m_cons + j]);
          if (m_acc.size() == W) begin
            load = 1; m_okeep = '1;
            for (int i = 0; i < W; i++) m_odata[i] = m_acc[i];
            m_acc.delete();
          end
          if (m_cons + n == k) begin er = 1; m_cons = 0; end
          else m_cons = m_cons + n;
        end
      end
      if (load) m_ov = 1;
      else if (rdy_in) m_ov = 0;
      if (exec || took || sz == 0) m_idle = 0;
      else if (!autof && m_idle < IMX) m_idle++;
      if (flush) m_pend = 1;
    end

    check_val("valid_o", 64'(vout), 64'(ev));
    check_val("ready_o", 64'(rdy_out), 64'(er));
    check_val("fill_count_o", 64'(fill_cnt), 64'(sz));
    if (ev) begin
      check_val("keep_o", 64'(keep), 64'(ek));
      check_val("data_o", 64'(dout), 64'(ed));
    end
    last_er = er;
  endtask

  task automatic new_beat();
    int k;
    logic [W-1:0] v;
    k = ($urandom_range(0, 9) < 2) ? 0 : int'($urandom_range(1, W));
    if ($urandom_range(0, 3) == 0) k = W;
    v = W'($urandom);
    for (int i = 0; i < W; i++) if (i < k) v[i] = 1'b1;
    if (k < W) v[k] = 1'b0;
    vin = v;
    for (int i = 0; i < W; i++) din[i] = 16'($urandom);
  endtask

  initial begin
    int tmo_tab[6] = '{0, 1, 2, 3, 5, 63};
    bit hold;
    // reset values
    repeat (2) @(negedge clk);
    check_val("rst valid_o", 64'(vout), 64'd0);
    check_val("rst ready_o", 64'(rdy_out), 64'd0);
    check_val("rst keep_o", 64'(keep), 64'd0);
    check_val("rst data_o", 64'(dout), 64'd0);
    check_val("rst fill_count_o", 64'(fill_cnt), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    hold = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk); #1;
      clear = 1'b0;
      if (cyc % 400 == 0) tmo = FCW'(tmo_tab[$urandom_range(0, 5)]);
      if (cyc == 4000 || cyc == 4600) begin
        byp_en = (cyc == 4000);
        clear  = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        clear = 1'b1;
      end
      if (!hold) new_beat();
      rdy_in = ($urandom_range(0, 9) < 7);
      flush  = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      model_cycle();
      hold = !clear && (ones_run(vin) > 0) && !last_er;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
